// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: command opcodes and controller states.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_COUNT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  function automatic logic is_step_op(input op_e op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/counter_seq_ctrl.sv
// Command sequencer for an external up/down counter: turns LOAD/UP/DOWN/NOP
// commands into preload and count-enable strobes, and flags wrap-around.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int DW = 8,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  input  logic [DW-1:0] cnt_value,
  output logic          ld_en,
  output logic          en,
  output logic          updwn,
  output logic [DW-1:0] datain,
  output logic          busy,
  output logic          done,
  output logic          wrap
);

  state_e        r_state;
  state_e        w_state_next;
  logic [DW-1:0] r_datain;
  logic          r_updwn;
  logic          r_wrap;
  logic [SW-1:0] r_remain;

  op_e           w_op;
  logic          w_accept;
  logic [SW-1:0] w_steps;
  logic          w_step_cmd;
  logic          w_wrap_hit;

  assign w_op     = op_e'(cmd_op);
  assign w_accept = cmd_valid && cmd_ready;

  // Step count comes from the low SW bits of cmd_data, zero-extended if wider.
  generate
    if (SW <= DW) begin : g_steps_trunc
      assign w_steps = cmd_data[SW-1:0];
    end else begin : g_steps_ext
      assign w_steps = {{(SW-DW){1'b0}}, cmd_data};
    end
  endgenerate

  assign w_step_cmd = is_step_op(w_op) && (w_steps != '0);
  assign w_wrap_hit = r_updwn ? (cnt_value == '1) : (cnt_value == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_op == OP_LOAD) begin
            w_state_next = ST_LOAD;
          end else if (w_step_cmd) begin
            w_state_next = ST_COUNT;
          end else begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_LOAD:  w_state_next = ST_DONE;
      ST_COUNT: begin
        if (r_remain == SW'(1)) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Handshake is held off while reset is asserted so nothing is accepted then.
  always_comb begin
    cmd_ready = (r_state == ST_IDLE) && rst_n;
    ld_en     = (r_state == ST_LOAD);
    en        = (r_state == ST_COUNT);
    done      = (r_state == ST_DONE);
    busy      = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_datain <= '0;
      r_updwn  <= 1'b0;
      r_remain <= '0;
      r_wrap   <= 1'b0;
    end else if (w_accept) begin
      r_wrap <= 1'b0;
      if (w_op == OP_LOAD) begin
        r_datain <= cmd_data;
      end
      // Direction only changes when a real count is about to run.
      if (w_step_cmd) begin
        r_updwn  <= (w_op == OP_UP);
        r_remain <= w_steps;
      end
    end else if (en) begin
      r_remain <= r_remain - SW'(1);
      if (w_wrap_hit) begin
        r_wrap <= 1'b1;
      end
    end
  end

  assign datain = r_datain;
  assign updwn  = r_updwn;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench: sequencer driving an 8-bit up/down counter whose output
// feeds back to cnt_value; expected results queued at issue, checked at done.
module tb_counter_seq_ctrl;
  import counter_seq_pkg::*;

  localparam int DW = 8;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'b11;
  logic [DW-1:0] cmd_data = '0;
  logic [DW-1:0] cnt_value;
  logic          cmd_ready, ld_en, en, updwn, busy, done, wrap;
  logic [DW-1:0] datain;
  logic [DW-1:0] dataout;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.DW(DW), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cnt_value(cnt_value),
    .ld_en(ld_en), .en(en), .updwn(updwn), .datain(datain),
    .busy(busy), .done(done), .wrap(wrap)
  );

  // Downstream 8-bit up/down counter with preload
  always @(posedge clk) begin
    if (!rst_n) dataout <= '0;
    else if (ld_en) dataout <= datain;
    else if (en) dataout <= updwn ? dataout + 8'd1 : dataout - 8'd1;
  end
  assign cnt_value = dataout;

  // Monitor: edge numbers of accept/done plus per-command strobe statistics
  int   edge_n = 0, acc_cnt = 0, done_cnt = 0, acc_edge = 0, done_edge = 0;
  int   m_en = 0, m_ld = 0;
  logic [7:0] m_ld_data = '0;
  logic m_upd0 = 1'b0, m_upd_bad = 1'b0, m_overlap = 1'b0;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (rst_n && cmd_valid && cmd_ready) begin
      acc_cnt   <= acc_cnt + 1;
      acc_edge  <= edge_n;
      m_en      <= 0;
      m_ld      <= 0;
      m_upd_bad <= 1'b0;
    end else begin
      if (en === 1'b1) begin
        m_en <= m_en + 1;
        if (m_en == 0) m_upd0 <= updwn;
        else if (updwn !== m_upd0) m_upd_bad <= 1'b1;
      end
      if (ld_en === 1'b1) begin
        m_ld      <= m_ld + 1;
        m_ld_data <= datain;
      end
    end
    if (en === 1'b1 && ld_en === 1'b1) m_overlap <= 1'b1;
    if (done === 1'b1) begin
      done_cnt  <= done_cnt + 1;
      done_edge <= edge_n;
      $display("txn %0d done: latency=%0d cnt_value=%02h wrap=%0b", done_cnt + 1,
               edge_n - acc_edge, cnt_value, wrap);
    end
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    int         lat;
    logic [7:0] cnt;
    logic       wrp;
    int         n_en;
    int         n_ld;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_cnt = '0;
  logic       m_wrap = 1'b0;
  int         n_vec = 0, n_err = 0;
  int         d0_g = 0;

  function automatic void predict(input logic [1:0] op, input logic [7:0] data);
    exp_t e;
    int   n;
    e.op = op; e.data = data; e.n_en = 0; e.n_ld = 0;
    m_wrap = 1'b0;
    n = int'(data);
    if (op == OP_LOAD) begin
      m_cnt = data; e.lat = 2; e.n_ld = 1;
    end else if ((op == OP_UP || op == OP_DOWN) && n > 0) begin
      for (int i = 0; i < n; i++) begin
        if (op == OP_UP) begin
          if (m_cnt == 8'hFF) m_wrap = 1'b1;
          m_cnt = m_cnt + 8'd1;
        end else begin
          if (m_cnt == 8'h00) m_wrap = 1'b1;
          m_cnt = m_cnt - 8'd1;
        end
      end
      e.lat = n + 1; e.n_en = n;
    end else begin
      e.lat = 1;
    end
    e.cnt = m_cnt; e.wrp = m_wrap;
    sb_q.push_back(e);
  endfunction

  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    int a0;
    d0_g = done_cnt;
    a0 = acc_cnt;
    predict(op, data);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    for (int t = 0; t < 64 && acc_cnt == a0; t++) @(negedge clk);
    cmd_valid = 1'b0;
    n_vec++;
    if (acc_cnt == a0) begin
      n_err++; $display("FAIL accept_timeout: op=%0d accepts=%0d required=%0d", op, acc_cnt, a0 + 1);
    end
  endtask

  task automatic wait_done(output bit ok);
    for (int t = 0; t < 300 && done_cnt == d0_g; t++) @(negedge clk);
    ok = (done_cnt != d0_g);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 8'h55;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({ld_en, en, updwn, done, wrap, busy, datain} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %b required all zero", {ld_en, en, updwn, done, wrap, busy, datain});
    end
    n_vec++;
    if (acc_cnt !== 0) begin
      n_err++; $display("FAIL reset_no_accept: accepts=%0d required=0", acc_cnt);
    end
    cmd_valid = 1'b0; rst_n = 1'b1;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b required 1", cmd_ready);
    end
    @(negedge clk);
    n_vec++;
    if ({cmd_ready, busy, done} !== 3'b100) begin
      n_err++; $display("FAIL reset_idle: ready/busy/done=%b required 100", {cmd_ready, busy, done});
    end
  endtask

  task automatic test_load;
    bit ok; exp_t e;
    issue(OP_LOAD, 8'h64);
    wait_done(ok);
    e = sb_q.pop_front();
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL load_done_timeout: no done pulse seen required one"); end
    n_vec++;
    if (done_edge - acc_edge !== e.lat) begin
      n_err++; $display("FAIL load_latency: got %0d required %0d", done_edge - acc_edge, e.lat);
    end
    n_vec++;
    if (m_ld !== e.n_ld || m_en !== e.n_en) begin
      n_err++; $display("FAIL load_strobes: ld=%0d en=%0d required ld=%0d en=%0d", m_ld, m_en, e.n_ld, e.n_en);
    end
    n_vec++;
    if (m_ld_data !== e.data) begin
      n_err++; $display("FAIL load_datain: got %02h required %02h", m_ld_data, e.data);
    end
    n_vec++;
    if (cnt_value !== e.cnt) begin
      n_err++; $display("FAIL load_counter: got %02h required %02h", cnt_value, e.cnt);
    end
    n_vec++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL load_done_width: done=%b one cycle after pulse required 0", done);
    end
  endtask

  task automatic test_down;
    bit ok; exp_t e;
    issue(OP_DOWN, 8'd5);
    wait_done(ok);
    e = sb_q.pop_front();
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL down_done_timeout: no done pulse seen required one"); end
    n_vec++;
    if (done_edge - acc_edge !== e.lat) begin
      n_err++; $display("FAIL down_latency: got %0d required %0d", done_edge - acc_edge, e.lat);
    end
    n_vec++;
    if (m_en !== e.n_en || m_ld !== 0 || m_upd_bad !== 1'b0) begin
      n_err++; $display("FAIL down_strobes: en=%0d ld=%0d upd_changed=%b required en=%0d ld=0 upd_changed=0", m_en, m_ld, m_upd_bad, e.n_en);
    end
    n_vec++;
    if (updwn !== 1'b0) begin
      n_err++; $display("FAIL down_updwn: got %b required 0", updwn);
    end
    n_vec++;
    if (cnt_value !== e.cnt || wrap !== e.wrp) begin
      n_err++; $display("FAIL down_result: cnt=%02h wrap=%b required cnt=%02h wrap=%b", cnt_value, wrap, e.cnt, e.wrp);
    end
    n_vec++;
    if (datain !== 8'h64) begin
      n_err++; $display("FAIL datain_hold: got %02h required 64", datain);
    end
  endtask

  task automatic test_wrap;
    bit ok; exp_t e;
    issue(OP_LOAD, 8'hFE);
    wait_done(ok);
    e = sb_q.pop_front();
    issue(OP_UP, 8'd3);
    wait_done(ok);
    e = sb_q.pop_front();
    n_vec++;
    if (!ok || cnt_value !== e.cnt || wrap !== e.wrp) begin
      n_err++; $display("FAIL wrap_up: done=%b cnt=%02h wrap=%b required done=1 cnt=%02h wrap=%b", ok, cnt_value, wrap, e.cnt, e.wrp);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (wrap !== 1'b1 || updwn !== 1'b1) begin
      n_err++; $display("FAIL wrap_sticky: wrap=%b updwn=%b required wrap=1 updwn=1", wrap, updwn);
    end
    issue(OP_DOWN, 8'd0);
    wait_done(ok);
    e = sb_q.pop_front();
    n_vec++;
    if (!ok || done_edge - acc_edge !== e.lat) begin
      n_err++; $display("FAIL zero_step_latency: got %0d required %0d", done_edge - acc_edge, e.lat);
    end
    n_vec++;
    if (wrap !== e.wrp || cnt_value !== e.cnt || m_en !== 0 || m_ld !== 0) begin
      n_err++; $display("FAIL zero_step_result: wrap=%b cnt=%02h en=%0d ld=%0d required wrap=%b cnt=%02h en=0 ld=0", wrap, cnt_value, m_en, m_ld, e.wrp, e.cnt);
    end
    n_vec++;
    if (updwn !== 1'b1) begin
      n_err++; $display("FAIL updwn_hold: got %b required 1", updwn);
    end
    issue(OP_NOP, 8'd7);
    wait_done(ok);
    e = sb_q.pop_front();
    n_vec++;
    if (!ok || done_edge - acc_edge !== e.lat || m_en !== 0 || cnt_value !== e.cnt) begin
      n_err++; $display("FAIL nop: lat=%0d en=%0d cnt=%02h required lat=%0d en=0 cnt=%02h", done_edge - acc_edge, m_en, cnt_value, e.lat, e.cnt);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   a0, de1;
    a0 = acc_cnt; d0_g = done_cnt;
    predict(OP_UP, 8'd2);
    predict(OP_LOAD, 8'h10);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_UP; cmd_data = 8'd2;
    for (int t = 0; t < 64 && acc_cnt == a0; t++) @(negedge clk);
    cmd_op = OP_LOAD; cmd_data = 8'h10;
    for (int t = 0; t < 64 && done_cnt == d0_g; t++) @(negedge clk);
    e = sb_q.pop_front();
    de1 = done_edge;
    n_vec++;
    if (done_cnt == d0_g || done_edge - acc_edge !== e.lat || cnt_value !== e.cnt) begin
      n_err++; $display("FAIL b2b_first: lat=%0d cnt=%02h required lat=%0d cnt=%02h", done_edge - acc_edge, cnt_value, e.lat, e.cnt);
    end
    for (int t = 0; t < 64 && acc_cnt < a0 + 2; t++) @(negedge clk);
    cmd_valid = 1'b0;
    n_vec++;
    if (acc_cnt !== a0 + 2 || acc_edge !== de1 + 1) begin
      n_err++; $display("FAIL b2b_accept_edge: accepts=%0d edge=%0d required accepts=%0d edge=%0d", acc_cnt - a0, acc_edge, 2, de1 + 1);
    end
    d0_g = d0_g + 1;
    for (int t = 0; t < 64 && done_cnt == d0_g; t++) @(negedge clk);
    e = sb_q.pop_front();
    n_vec++;
    if (done_cnt == d0_g || done_edge - acc_edge !== e.lat || cnt_value !== e.cnt || m_ld_data !== e.data) begin
      n_err++; $display("FAIL b2b_second: lat=%0d cnt=%02h ld_data=%02h required lat=%0d cnt=%02h ld_data=%02h", done_edge - acc_edge, cnt_value, m_ld_data, e.lat, e.cnt, e.data);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (acc_cnt !== a0 + 2) begin
      n_err++; $display("FAIL b2b_no_duplicate: accepts=%0d required 2", acc_cnt - a0);
    end
  endtask

  task automatic test_reset_mid;
    bit ok; exp_t e;
    issue(OP_UP, 8'd10);
    for (int t = 0; t < 64 && m_en < 4; t++) @(negedge clk);
    void'(sb_q.pop_back());
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({en, ld_en, done, busy} !== 4'b0000) begin
      n_err++; $display("FAIL midreset_outputs: en/ld_en/done/busy=%b required 0000", {en, ld_en, done, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = '0; m_wrap = 1'b0;
    repeat (15) @(negedge clk);
    n_vec++;
    if (done_cnt !== d0_g || cnt_value !== 8'h00 || updwn !== 1'b0) begin
      n_err++; $display("FAIL midreset_abort: dones=%0d cnt=%02h updwn=%b required dones=%0d cnt=00 updwn=0", done_cnt, cnt_value, updwn, d0_g);
    end
    issue(OP_LOAD, 8'h33);
    wait_done(ok);
    e = sb_q.pop_front();
    n_vec++;
    if (!ok || cnt_value !== e.cnt || done_edge - acc_edge !== e.lat) begin
      n_err++; $display("FAIL midreset_recover: cnt=%02h lat=%0d required cnt=%02h lat=%0d", cnt_value, done_edge - acc_edge, e.cnt, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_down();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    n_vec++;
    if (m_overlap !== 1'b0) begin
      n_err++; $display("FAIL strobe_overlap: got %b required 0", m_overlap);
    end
    n_vec++;
    if (sb_q.size() !== 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d left required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter DW, default 8, counter data width (matches the downstream 8-bit up/down counter).
REQ-002 Parameter SW, default 8, step-count width.
REQ-003 clk  input  1  clock, all logic on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_op  input  2  opcode: 00 LOAD, 01 UP, 10 DOWN, 11 NOP.
REQ-008 cmd_data  input  DW  load value (LOAD) or step count N (UP/DOWN; low SW bits used).
REQ-009 cnt_value  input  DW  current counter output, fed back for wrap detection.
REQ-010 ld_en  output  1  counter preload strobe.
REQ-011 en  output  1  counter count enable.
REQ-012 updwn  output  1  count direction, 1 = up, 0 = down.
REQ-013 datain  output  DW  preload value to counter.
REQ-014 busy  output  1  command in progress.
REQ-015 done  output  1  single-cycle command-complete pulse.
REQ-016 wrap  output  1  sticky wrap-around flag for the current command.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, COUNT, DONE; all outputs registered or decoded from state only.
REQ-018 cmd_ready SHALL be 1 only in IDLE and SHALL NOT depend on cmd_valid.
REQ-019 Accept SHALL occur on an edge with cmd_valid && cmd_ready; op and data are captured, and the command is never dropped or duplicated.
REQ-020 LOAD accepted at edge k: ld_en=1 and datain=cmd_data during cycle k+1; done=1 in cycle k+2; IDLE in cycle k+3.
REQ-021 UP/DOWN with N>0 accepted at edge k: en=1 with updwn constant for exactly N cycles (k+1..k+N); done=1 in cycle k+N+1.
REQ-022 UP/DOWN with N=0, and NOP, SHALL go directly to DONE: done in cycle k+1, en and ld_en stay 0.
REQ-023 ld_en and en SHALL never be 1 in the same cycle.
REQ-024 The remaining-step counter SHALL be SW bits and decrement once per en cycle; leave COUNT on the edge where remaining==1.
REQ-025 datain SHALL hold the last loaded value between commands.
REQ-026 updwn SHALL hold its last value outside COUNT.
REQ-027 busy SHALL equal (state != IDLE).
REQ-028 wrap SHALL be cleared on accept.
REQ-029 wrap SHALL be set on an edge with en=1 and either updwn=1 with cnt_value=all-ones, or updwn=0 with cnt_value=0; it then holds until the next accept.
REQ-030 cmd_valid asserted while busy SHALL be ignored until the block returns to IDLE; the command is then accepted in the first IDLE cycle.

Reset
REQ-031 While rst_n=0 at posedge: state=IDLE, ld_en=0, en=0, updwn=0, datain=0, done=0, wrap=0, step counter=0, busy=0; cmd_ready=1 from the first cycle after reset.
REQ-032 Reset mid-command SHALL abort the command without a done pulse, and en/ld_en SHALL be 0 in the next cycle.

Structure
REQ-033 Package counter_seq_pkg SHALL hold the opcode enum (OP_LOAD, OP_UP, OP_DOWN, OP_NOP) and the state enum.
REQ-034 The block SHALL be a single module with no sub-modules; the FSM and step counter stay in counter_seq_ctrl.

Verification
REQ-035 Bench SHALL instantiate counter_seq_ctrl driving the 8-bit counter, with dataout looped to cnt_value.
REQ-036 Reset: rst_n=0 for 2 cycles with cmd_valid=1 -> no accept; all outputs 0; cmd_ready=1 after release.
REQ-037 LOAD 8'h64 -> ld_en pulse of 1 cycle with datain=100; counter=100; done 2 cycles after accept.
REQ-038 DOWN N=5 after LOAD 100 -> en high 5 cycles, updwn=0; counter=95; done at accept+6; wrap=0.
REQ-039 LOAD 8'hFE then UP N=3 -> counter=1; wrap=1 until next accept; DOWN N=0 -> done at accept+1, wrap=0, counter unchanged.
REQ-040 Back-to-back: cmd_valid held high with UP N=2 then LOAD 8'h10 -> second accept in first IDLE cycle after done; rst_n=0 during UP N=10 at step 4 -> no done pulse, en=0 next cycle.
